ins_sequencer: RTL

Sequences a program of 32-bit instructions, stored in an instruction BRAM, into the compute controller. Each instruction is issued with the controller's en/ins handshake.
- The next instruction is issued only after the controller reports valid for the previous one.
- Host side: start a run from a base address for N instructions; a done pulse marks completion.
- The run terminates early on a HALT opcode, an abort request or a per-instruction timeout.

---
 rtl/ins_sequencer_pkg.sv | 26 ++
 rtl/ins_sequencer_if.sv | 28 ++
 rtl/ins_sequencer_timeout_cnt.sv | 39 +++
 rtl/ins_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ins_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// default widths and the HALT opcode field.
package ins_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_CTRL = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_INS_W  = 32;

    // Opcode field of an instruction word and the value that ends a run
    localparam int         OP_MSB  = 31;
    localparam int         OP_LSB  = 28;
    localparam logic [3:0] HALT_OP = 4'hF;

    function automatic logic [3:0] opcode_of(input logic [DEF_INS_W-1:0] ins);
        return ins[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/ins_sequencer_if.sv
// Bus bundle between the sequencer, its instruction BRAM and the compute
// controller. The sequencer is the master; BRAM/controller form the slave.
interface ins_sequencer_if
    import ins_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INS_W  = DEF_INS_W
) ();

    logic [ADDR_W-1:0] imem_addr;
    logic              imem_en;
    logic [INS_W-1:0]  imem_data;
    logic              ctrl_en;
    logic [INS_W-1:0]  ctrl_ins;
    logic              ctrl_busy;
    logic              ctrl_valid;

    modport master (
        output imem_addr, imem_en, ctrl_en, ctrl_ins,
        input  imem_data, ctrl_busy, ctrl_valid
    );

    modport slave (
        input  imem_addr, imem_en, ctrl_en, ctrl_ins,
        output imem_data, ctrl_busy, ctrl_valid
    );

endinterface

// File: rtl/ins_sequencer_timeout_cnt.sv
// Loadable down-counter guarding the wait for controller completion.
// Loaded with LOAD_VAL when an instruction is issued; expire_o is raised
// in the LOAD_VAL-th counting cycle so the caller can give up at that edge.
module seq_timeout_cnt #(
    parameter int CNT_W    = 10,
    parameter int LOAD_VAL = 1023
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on issue, otherwise count down while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = dec_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ins_sequencer.sv
// Instruction sequencer: fetches a run of instructions from BRAM and hands
// them one at a time to the compute controller, waiting for each to
// complete. Runs end on count, HALT opcode, abort or controller timeout.
module ins_sequencer
    import ins_sequencer_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INS_W   = DEF_INS_W,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   num_ins_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   issued_cnt_o,
    ins_sequencer_if.master   bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   num_q;
    logic [ADDR_W:0]   issued_q;
    logic [ADDR_W:0]   issued_inc;
    logic              err_q;
    logic [INS_W-1:0]  ctrl_ins_q;
    logic              issue_fire;
    logic              tmo_expire;

    assign issued_inc = issued_q + 1'b1;

    // Issue happens in the first ISSUE cycle the controller is free,
    // unless the run is being aborted in that same cycle.
    assign issue_fire = (state_q == S_ISSUE) && !bus.ctrl_busy && !abort_i;

    seq_timeout_cnt #(
        .CNT_W    (CNT_W),
        .LOAD_VAL (TIMEOUT)
    ) u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (issue_fire),
        .dec_i    (state_q == S_WAIT_CTRL),
        .expire_o (tmo_expire)
    );

    // Run control FSM; abort overrides every transition out of a busy state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            err_q      <= 1'b0;
            ctrl_ins_q <= '0;
        end else if (abort_i && (state_q != S_IDLE)) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        ptr_q    <= base_addr_i;
                        num_q    <= num_ins_i;
                        issued_q <= '0;
                        err_q    <= 1'b0;
                        state_q  <= (num_ins_i == '0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    // HALT ends the run without ever reaching the controller
                    if (opcode_of(bus.imem_data) == HALT_OP) begin
                        state_q <= S_DONE;
                    end else begin
                        ctrl_ins_q <= bus.imem_data;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_fire) begin
                        state_q <= S_WAIT_CTRL;
                    end
                end
                S_WAIT_CTRL: begin
                    // Completion beats a timeout landing in the same cycle
                    if (bus.ctrl_valid) begin
                        issued_q <= issued_inc;
                        if (issued_inc == num_q) begin
                            state_q <= S_DONE;
                        end else begin
                            ptr_q   <= ptr_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end else if (tmo_expire) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign issued_cnt_o  = issued_q;
    assign bus.imem_en   = (state_q == S_FETCH);
    assign bus.imem_addr = ptr_q;
    assign bus.ctrl_en   = issue_fire;
    assign bus.ctrl_ins  = ctrl_ins_q;

endmodule
